// File: rtl/wb_timer_slave_pkg.sv
// Shared constants for the Wishbone timer slave: register map, CTRL bit
// positions and a small address helper.
package wb_timer_slave_pkg;

    localparam logic [2:0] ADR_CTRL   = 3'd0;
    localparam logic [2:0] ADR_STATUS = 3'd1;
    localparam logic [2:0] ADR_RLDLO  = 3'd2;
    localparam logic [2:0] ADR_RLDHI  = 3'd3;
    localparam logic [2:0] ADR_CNTLO  = 3'd4;
    localparam logic [2:0] ADR_CNTHI  = 3'd5;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AUTO  = 1;
    localparam int CTRL_IRQEN = 2;
    localparam int PSEL_LSB   = 3;
    localparam int STATUS_EXP = 0;

    function automatic logic adr_unmapped(input logic [2:0] adr);
        return adr >= 3'd6;
    endfunction

endpackage

// File: rtl/wb_timer_slave_timer_core.sv
// Prescaler plus 16-bit down-counter; flags expiry and the one-shot EN clear
// combinationally so the register file can update on the same edge.
module wb_timer_slave_timer_core #(
    parameter int PRESC_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_i,
    input  logic               auto_i,
    input  logic [PRESC_W-1:0] psel_i,
    input  logic               load_i,
    input  logic [15:0]        reload_i,
    output logic [15:0]        count_o,
    output logic               expire_o,
    output logic               auto_clear_en_o
);

    localparam int PRE_W = (1 << PRESC_W) - 1;
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    logic [PRE_W-1:0] presc_q, presc_d, presc_lim;
    logic [15:0]      count_q, count_d;
    logic             tick;

    // Terminal prescaler value is 2^psel - 1; psel = 0 ticks every cycle.
    assign presc_lim       = (PRE_ONE << psel_i) - PRE_ONE;
    assign tick            = en_i && (presc_q == presc_lim);
    assign expire_o        = tick && (count_q == 16'd1);
    assign auto_clear_en_o = expire_o && !auto_i;
    assign count_o         = count_q;

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        if (load_i) begin
            presc_d = '0;
            count_d = reload_i;
        end else if (en_i) begin
            presc_d = tick ? '0 : presc_q + PRE_ONE;
            if (tick) begin
                if (count_q == 16'd1) begin
                    count_d = auto_i ? reload_i : 16'd0;
                end else begin
                    count_d = count_q - 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            count_q <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_timer_slave.sv
// Wishbone classic timer slave: bus decode, register file and interrupt;
// the counting itself lives in wb_timer_slave_timer_core.
module wb_timer_slave
    import wb_timer_slave_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter logic [15:0] RELOAD_RST = 16'hFFFF,
    parameter int          PRESC_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic              we_i,
    input  logic              stb_i,
    input  logic              cyc_i,
    input  logic [7:0]        dat_i,
    output logic [7:0]        dat_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              rty_o,
    output logic              irq_o
);

    localparam int CTRL_W = PSEL_LSB + PRESC_W;

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              exp_q, exp_d;
    logic [15:0]       reload_q, reload_d;
    logic [7:0]        snap_q, snap_d;
    logic [7:0]        dat_q, dat_d;
    logic              ack_q, err_q, irq_q;

    logic [2:0]  adr;
    logic        req, bad, wr, rd, ctrl_wr;
    logic        core_en, core_load, expire, auto_clear_en;
    logic [15:0] count;
    logic [7:0]  rd_data;
    logic        adr_hi_unused;

    assign adr           = adr_i[2:0];
    assign adr_hi_unused = ^adr_i[ADDR_W-1:3];

    // Handshake: a request is stb_i & cyc_i sampled on a rising edge while no
    // termination is showing; exactly one of ack_o/err_o answers it for one
    // cycle on the next edge, so a held strobe completes every second cycle.
    assign req = stb_i && cyc_i && !ack_q && !err_q;
    assign bad = adr_unmapped(adr)
              || (we_i && (adr == ADR_CNTLO || adr == ADR_CNTHI))
              || (we_i && adr == ADR_CTRL && dat_i[CTRL_EN] && reload_q == 16'd0);
    assign wr      = req && we_i && !bad;
    assign rd      = req && !we_i && !bad;
    assign ctrl_wr = wr && (adr == ADR_CTRL);

    // A CTRL write clearing EN overrides a coincident tick.
    assign core_load = ctrl_wr && dat_i[CTRL_EN] && !ctrl_q[CTRL_EN];
    assign core_en   = ctrl_q[CTRL_EN] && !(ctrl_wr && !dat_i[CTRL_EN]);

    wb_timer_slave_timer_core #(
        .PRESC_W (PRESC_W)
    ) u_timer_core (
        .clk             (clk),
        .reset           (reset),
        .en_i            (core_en),
        .auto_i          (ctrl_q[CTRL_AUTO]),
        .psel_i          (ctrl_q[PSEL_LSB +: PRESC_W]),
        .load_i          (core_load),
        .reload_i        (reload_q),
        .count_o         (count),
        .expire_o        (expire),
        .auto_clear_en_o (auto_clear_en)
    );

    always_comb begin
        rd_data = 8'h00;
        case (adr)
            ADR_CTRL:   rd_data = 8'(ctrl_q);
            ADR_STATUS: rd_data = {7'd0, exp_q};
            ADR_RLDLO:  rd_data = reload_q[7:0];
            ADR_RLDHI:  rd_data = reload_q[15:8];
            ADR_CNTLO:  rd_data = count[7:0];
            ADR_CNTHI:  rd_data = snap_q;
            default:    rd_data = 8'h00;
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        exp_d    = exp_q;
        reload_d = reload_q;
        snap_d   = snap_q;
        dat_d    = rd ? rd_data : 8'h00;
        if (auto_clear_en) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end
        if (ctrl_wr) begin
            ctrl_d = dat_i[CTRL_W-1:0];
        end
        if (wr && adr == ADR_RLDLO) reload_d[7:0]  = dat_i;
        if (wr && adr == ADR_RLDHI) reload_d[15:8] = dat_i;
        if (rd && adr == ADR_CNTLO) snap_d = count[15:8];
        // Expiry beats a coincident write-1-to-clear.
        if (wr && adr == ADR_STATUS && dat_i[STATUS_EXP]) exp_d = 1'b0;
        if (expire) exp_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= '0;
            exp_q    <= 1'b0;
            reload_q <= RELOAD_RST;
            snap_q   <= 8'h00;
            dat_q    <= 8'h00;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            exp_q    <= exp_d;
            reload_q <= reload_d;
            snap_q   <= snap_d;
            dat_q    <= dat_d;
            ack_q    <= req && !bad;
            err_q    <= req && bad;
            irq_q    <= exp_q && ctrl_q[CTRL_IRQEN];
        end
    end

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign err_o = err_q;
    assign rty_o = 1'b0;
    assign irq_o = irq_q;

endmodule

// File: tb/tb_wb_timer_slave.sv
// Bench for wb_timer_slave: a register-map vector table plus timed sequences
// for counting, expiry, simultaneous events and asynchronous reset.
module tb_wb_timer_slave;
    import wb_timer_slave_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [11:0] adr;
    logic        we, stb, cyc;
    logic [7:0]  dat;
    logic [7:0]  dat_o;
    logic        ack_o, err_o, rty_o, irq_o;

    typedef struct packed {
        logic       we;
        logic [2:0] adr;
        logic [7:0] dat;
        logic       ack;
        logic       err;
        logic [7:0] rdat;
    } vec_t;

    vec_t       vecs [24];
    logic [9:0] exp_q [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n;

    wb_timer_slave #(
        .ADDR_W     (12),
        .RELOAD_RST (16'hFFFF),
        .PRESC_W    (3)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .adr_i (adr),
        .we_i  (we),
        .stb_i (stb),
        .cyc_i (cyc),
        .dat_i (dat),
        .dat_o (dat_o),
        .ack_o (ack_o),
        .err_o (err_o),
        .rty_o (rty_o),
        .irq_o (irq_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic w, input logic [2:0] a, input logic [7:0] d,
                                input logic ak, input logic er, input logic [7:0] rd);
        vec_t v;
        v.we = w; v.adr = a; v.dat = d; v.ack = ak; v.err = er; v.rdat = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_tests++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req_v);
        end
    endtask

    // driver: idle cycles, then one held strobe until a termination (bounded)
    task automatic bus(input int idle_n, input logic w, input logic [2:0] a, input logic [7:0] d,
                       input logic ack_e, input logic err_e, input logic [7:0] dat_e, input string name);
        int k;
        logic [9:0] e;
        repeat (idle_n) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        adr = 12'(a);
        we  = w;
        dat = d;
        stb = 1'b1;
        cyc = 1'b1;
        exp_q.push_back({ack_e, err_e, dat_e});
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!(ack_o || err_o) && k < 8);
        e = exp_q.pop_front();
        check(name, 32'({ack_o, err_o, dat_o}), 32'(e));
        stb = 1'b0;
        cyc = 1'b0;
        we  = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        bus(0, v.we, v.adr, v.dat, v.ack, v.err, v.rdat, $sformatf("vec%0d_adr%0d", i, v.adr));
    endtask

    task automatic wait_irq(input int max_cyc, output int cyc_n);
        cyc_n = 0;
        while (!irq_o && cyc_n < max_cyc) begin
            @(posedge clk); #1;
            cyc_n++;
        end
    endtask

    initial begin
        vecs[0]  = mk(1'b0, ADR_CTRL,   8'h00, 1'b1, 1'b0, 8'h00);
        vecs[1]  = mk(1'b0, ADR_STATUS, 8'h00, 1'b1, 1'b0, 8'h00);
        vecs[2]  = mk(1'b0, ADR_RLDLO,  8'h00, 1'b1, 1'b0, 8'hFF);
        vecs[3]  = mk(1'b0, ADR_RLDHI,  8'h00, 1'b1, 1'b0, 8'hFF);
        vecs[4]  = mk(1'b0, ADR_CNTLO,  8'h00, 1'b1, 1'b0, 8'h00);
        vecs[5]  = mk(1'b0, ADR_CNTHI,  8'h00, 1'b1, 1'b0, 8'h00);
        vecs[6]  = mk(1'b0, 3'd6,       8'h00, 1'b0, 1'b1, 8'h00);
        vecs[7]  = mk(1'b0, 3'd7,       8'h00, 1'b0, 1'b1, 8'h00);
        vecs[8]  = mk(1'b1, ADR_CNTLO,  8'h55, 1'b0, 1'b1, 8'h00);
        vecs[9]  = mk(1'b1, ADR_CNTHI,  8'hAA, 1'b0, 1'b1, 8'h00);
        vecs[10] = mk(1'b1, ADR_RLDLO,  8'h34, 1'b1, 1'b0, 8'h00);
        vecs[11] = mk(1'b1, ADR_RLDHI,  8'h12, 1'b1, 1'b0, 8'h00);
        vecs[12] = mk(1'b0, ADR_RLDLO,  8'h00, 1'b1, 1'b0, 8'h34);
        vecs[13] = mk(1'b0, ADR_RLDHI,  8'h00, 1'b1, 1'b0, 8'h12);
        vecs[14] = mk(1'b1, ADR_CTRL,   8'h06, 1'b1, 1'b0, 8'h00);
        vecs[15] = mk(1'b0, ADR_CTRL,   8'h00, 1'b1, 1'b0, 8'h06);
        vecs[16] = mk(1'b1, ADR_CTRL,   8'hFE, 1'b1, 1'b0, 8'h00);
        vecs[17] = mk(1'b0, ADR_CTRL,   8'h00, 1'b1, 1'b0, 8'h3E);
        vecs[18] = mk(1'b1, ADR_CTRL,   8'h00, 1'b1, 1'b0, 8'h00);
        vecs[19] = mk(1'b1, ADR_RLDLO,  8'h00, 1'b1, 1'b0, 8'h00);
        vecs[20] = mk(1'b1, ADR_RLDHI,  8'h00, 1'b1, 1'b0, 8'h00);
        vecs[21] = mk(1'b1, ADR_CTRL,   8'h01, 1'b0, 1'b1, 8'h00);
        vecs[22] = mk(1'b0, ADR_CTRL,   8'h00, 1'b1, 1'b0, 8'h00);
        vecs[23] = mk(1'b0, ADR_STATUS, 8'h00, 1'b1, 1'b0, 8'h00);

        rst_n = 1'b0;
        adr = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0; dat = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({ack_o, err_o, rty_o, irq_o, dat_o}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // register map, error terminations, rejected EN with RELOAD=0
        for (int i = 0; i < 24; i++) run_vec(i);
        check("map_irq_low", 32'(irq_o), 32'd0);

        // auto-reload, PSEL=0: load edge E0, expiries at E4, E8, ...
        bus(0, 1'b1, ADR_RLDLO, 8'h04, 1'b1, 1'b0, 8'h00, "a_rld_lo");
        bus(0, 1'b1, ADR_CTRL,  8'h07, 1'b1, 1'b0, 8'h00, "a_ctrl");
        wait_irq(20, n);
        check("a_irq_latency", 32'(n), 32'd5);
        bus(0, 1'b0, ADR_CNTLO, 8'h00, 1'b1, 1'b0, 8'h03, "a_cnt_3");
        bus(0, 1'b0, ADR_CNTLO, 8'h00, 1'b1, 1'b0, 8'h01, "a_cnt_1");
        bus(2, 1'b0, ADR_CNTLO, 8'h00, 1'b1, 1'b0, 8'h02, "a_cnt_2");
        bus(0, 1'b0, ADR_CNTLO, 8'h00, 1'b1, 1'b0, 8'h04, "a_cnt_4");
        bus(0, 1'b1, ADR_STATUS, 8'h01, 1'b1, 1'b0, 8'h00, "a_w1c");
        check("a_irq_hold", 32'(irq_o), 32'd1);
        @(posedge clk); #1;
        check("a_irq_drop", 32'(irq_o), 32'd0);
        @(posedge clk); #1;
        check("a_irq_next_period", 32'(irq_o), 32'd1);
        bus(2, 1'b1, ADR_STATUS, 8'h01, 1'b1, 1'b0, 8'h00, "a_w1c_at_expiry");
        bus(0, 1'b0, ADR_STATUS, 8'h00, 1'b1, 1'b0, 8'h01, "a_exp_set_wins");
        bus(0, 1'b1, ADR_CTRL,   8'h06, 1'b1, 1'b0, 8'h00, "a_en_clear_at_tick");
        bus(0, 1'b0, ADR_CNTLO,  8'h00, 1'b1, 1'b0, 8'h01, "a_cnt_unchanged");
        bus(0, 1'b0, ADR_CNTHI,  8'h00, 1'b1, 1'b0, 8'h00, "a_cnt_hi");
        bus(5, 1'b0, ADR_CNTLO,  8'h00, 1'b1, 1'b0, 8'h01, "a_cnt_holds");
        bus(0, 1'b1, ADR_STATUS, 8'h01, 1'b1, 1'b0, 8'h00, "a_w1c2");
        bus(0, 1'b0, ADR_STATUS, 8'h00, 1'b1, 1'b0, 8'h00, "a_exp_cleared");
        check("a_irq_off", 32'(irq_o), 32'd0);

        // one-shot, PSEL=3, RELOAD=3: expiry 24 cycles after load
        bus(0, 1'b1, ADR_RLDLO, 8'h03, 1'b1, 1'b0, 8'h00, "b_rld_lo");
        bus(0, 1'b1, ADR_CTRL,  8'h1D, 1'b1, 1'b0, 8'h00, "b_ctrl");
        wait_irq(60, n);
        check("b_irq_latency", 32'(n), 32'd25);
        bus(0, 1'b0, ADR_CTRL,   8'h00, 1'b1, 1'b0, 8'h1C, "b_en_cleared");
        bus(0, 1'b0, ADR_CNTLO,  8'h00, 1'b1, 1'b0, 8'h00, "b_cnt_lo_zero");
        bus(0, 1'b0, ADR_CNTHI,  8'h00, 1'b1, 1'b0, 8'h00, "b_cnt_hi_zero");
        bus(0, 1'b1, ADR_STATUS, 8'h01, 1'b1, 1'b0, 8'h00, "b_w1c");
        bus(40, 1'b0, ADR_STATUS, 8'h00, 1'b1, 1'b0, 8'h00, "b_no_second_expiry");

        // COUNT_HI returns the snapshot taken by the COUNT_LO read
        bus(0, 1'b1, ADR_RLDHI, 8'h01, 1'b1, 1'b0, 8'h00, "d_rld_hi");
        bus(0, 1'b1, ADR_CTRL,  8'h01, 1'b1, 1'b0, 8'h00, "d_ctrl");
        bus(0, 1'b0, ADR_CNTLO, 8'h00, 1'b1, 1'b0, 8'h02, "d_cnt_lo");
        bus(5, 1'b0, ADR_CNTHI, 8'h00, 1'b1, 1'b0, 8'h01, "d_snapshot");
        bus(0, 1'b1, ADR_CTRL,  8'h00, 1'b1, 1'b0, 8'h00, "d_stop");

        // asynchronous reset while irq_o=1 and ack_o=1
        bus(0, 1'b1, ADR_RLDHI, 8'h00, 1'b1, 1'b0, 8'h00, "c_rld_hi");
        bus(0, 1'b1, ADR_CTRL,  8'h07, 1'b1, 1'b0, 8'h00, "c_ctrl");
        wait_irq(20, n);
        check("c_irq_latency", 32'(n), 32'd4);
        @(negedge clk);
        adr = 12'(ADR_STATUS); we = 1'b0; stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        check("c_pre_reset", 32'({ack_o, irq_o, dat_o}), 32'({1'b1, 1'b1, 8'h01}));
        #2;
        rst_n = 1'b0;
        #1;
        check("c_async_reset", 32'({ack_o, err_o, rty_o, irq_o, dat_o}), 32'd0);
        stb = 1'b0; cyc = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) run_vec(i);
        check("c_irq_after_reset", 32'(irq_o), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
